// File: rtl/pe_serial_mac.sv
// Radix-2^BPC serial multiply-accumulate PE. The multiplier is consumed BPC bits per cycle and
// the result is accumulated locally or onto an upstream partial sum. Accepted operands are forwarded.
module pe_serial_mac #(
   parameter int IWIDTH = 8,
   parameter int BPC    = 1,
   parameter int OWIDTH = 24,
   parameter int SIGNED = 1,
   parameter int SAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              add_in,
   input  logic              clr,
   input  logic [IWIDTH-1:0] ifm,
   input  logic [IWIDTH-1:0] wght,
   input  logic [OWIDTH-1:0] sum_i,
   output logic [IWIDTH-1:0] ifm_d,
   output logic [IWIDTH-1:0] wght_d,
   output logic              start_d,
   output logic              busy,
   output logic              done,
   output logic [OWIDTH-1:0] ofm_d,
   output logic              ovf
);

   localparam int N  = IWIDTH / BPC;
   localparam int PW = 2 * IWIDTH;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       mcand_q, mcand_d;
   logic [PW-1:0]       partial_q, partial_d;
   logic [IWIDTH-1:0]   mult_q, mult_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                mode_q, mode_d;
   logic [IWIDTH-1:0]   ifm_fwd_q, ifm_fwd_d;
   logic [IWIDTH-1:0]   wght_fwd_q, wght_fwd_d;
   logic                start_d_q, start_d_d;
   logic                done_q, done_d;
   logic [OWIDTH-1:0]   acc_q, acc_d;
   logic                ovf_q, ovf_d;

   logic [PW-1:0]       chunk_x, term, prod;
   logic [OWIDTH-1:0]   prod_x, base, sat_val, result;
   logic [OWIDTH:0]     sum_x;
   logic                of_flag;

   always_comb begin : arith
      // only the top chunk carries a negative weight in two's-complement mode
      chunk_x = '0;
      chunk_x[BPC-1:0] = mult_q[BPC-1:0];
      if (SIGNED != 0 && cnt_q == LAST) begin
         chunk_x = PW'($signed(mult_q[BPC-1:0]));
      end
      term = (mcand_q * chunk_x) << (32'(cnt_q) * BPC);
      prod = partial_q + term;
      base = mode_q ? sum_i : (clr ? '0 : acc_q);
      if (SIGNED != 0) begin
         prod_x  = OWIDTH'($signed(prod));
         sum_x   = (OWIDTH+1)'($signed(base)) + (OWIDTH+1)'($signed(prod_x));
         of_flag = sum_x[OWIDTH] ^ sum_x[OWIDTH-1];
         sat_val = {sum_x[OWIDTH], {(OWIDTH-1){~sum_x[OWIDTH]}}};
      end else begin
         prod_x  = OWIDTH'(prod);
         sum_x   = {1'b0, base} + {1'b0, prod_x};
         of_flag = sum_x[OWIDTH];
         sat_val = '1;
      end
      result = (of_flag && SAT != 0) ? sat_val : sum_x[OWIDTH-1:0];
   end

   always_comb begin : next_state
      state_d    = state_q;
      mcand_d    = mcand_q;
      partial_d  = partial_q;
      mult_d     = mult_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      ifm_fwd_d  = ifm_fwd_q;
      wght_fwd_d = wght_fwd_q;
      start_d_d  = 1'b0;
      done_d     = 1'b0;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (clr) begin
               acc_d = '0;
               ovf_d = 1'b0;
            end
            if (start) begin
               state_d    = BUSY;
               mcand_d    = (SIGNED != 0) ? PW'($signed(ifm)) : PW'(ifm);
               mult_d     = wght;
               mode_d     = add_in;
               cnt_d      = '0;
               partial_d  = '0;
               ifm_fwd_d  = ifm;
               wght_fwd_d = wght;
               start_d_d  = 1'b1;
            end
         end
         BUSY: begin
            partial_d = prod;
            mult_d    = mult_q >> BPC;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q != LAST) begin
               if (clr) begin
                  acc_d = '0;
                  ovf_d = 1'b0;
               end
            end else begin
               acc_d   = result;
               ovf_d   = (clr ? 1'b0 : ovf_q) | of_flag;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mcand_q    <= '0;
         partial_q  <= '0;
         mult_q     <= '0;
         cnt_q      <= '0;
         mode_q     <= 1'b0;
         ifm_fwd_q  <= '0;
         wght_fwd_q <= '0;
         start_d_q  <= 1'b0;
         done_q     <= 1'b0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         mcand_q    <= mcand_d;
         partial_q  <= partial_d;
         mult_q     <= mult_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         ifm_fwd_q  <= ifm_fwd_d;
         wght_fwd_q <= wght_fwd_d;
         start_d_q  <= start_d_d;
         done_q     <= done_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ifm_d   = ifm_fwd_q;
   assign wght_d  = wght_fwd_q;
   assign start_d = start_d_q;
   assign busy    = (state_q == BUSY);
   assign done    = done_q;
   assign ofm_d   = acc_q;
   assign ovf     = ovf_q;

endmodule
